// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
//
// Shared definitions for the serial pattern transmitter and its 10110 tracker.
//
// Contents:
//   tx_state_t  - transmitter control states (IDLE, SHIFT, DONE)
//   PATTERN     - the 5-bit sequence the tracker counts, oldest bit first
//                 (PATTERN[4] is the first bit of the sequence on the wire)
//   trk_state_t - tracker states, named after the longest pattern prefix
//                 that is currently a suffix of the observed stream
// -----------------------------------------------------------------------------
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } tx_state_t;

    localparam logic [4:0] PATTERN = 5'b10110;

    typedef enum logic [2:0] {
        TRK_NONE,
        TRK_1,
        TRK_10,
        TRK_101,
        TRK_1011
    } trk_state_t;

endpackage

// File: rtl/serial_pattern_tx_tracker.sv
// -----------------------------------------------------------------------------
// pattern_tracker
//
// Overlapping Mealy detector for the 10110 sequence. One bit is consumed on
// every cycle where bit_vld is high; `hit` is a combinational one-cycle flag
// raised while the completing bit is presented, so a counter registering it
// shows the match one cycle after that bit.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   clr      in   synchronous clear back to the initial state (wins over a bit)
//   bit_in   in   serial bit under observation
//   bit_vld  in   bit_in carries a real stream bit this cycle
//   hit      out  the current bit completes a 10110 occurrence
// -----------------------------------------------------------------------------
module pattern_tracker
    import serial_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic bit_in,
    input  logic bit_vld,
    output logic hit
);

    trk_state_t state;
    trk_state_t next_state;

    // State register; the tracker remembers the stream across frames, so only
    // reset or an explicit clear brings it back to the empty prefix.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= TRK_NONE;
        end else begin
            state <= next_state;
        end
    end

    // Prefix transitions. On a mismatch the state falls back to the longest
    // prefix that is still a suffix of what was seen, which is what makes
    // overlapping occurrences count (e.g. after 10110 we already hold "10").
    always_comb begin
        next_state = state;
        hit        = 1'b0;
        if (clr) begin
            next_state = TRK_NONE;
        end else if (bit_vld) begin
            case (state)
                TRK_NONE: begin
                    next_state = (bit_in == PATTERN[4]) ? TRK_1 : TRK_NONE;
                end
                TRK_1: begin
                    next_state = (bit_in == PATTERN[3]) ? TRK_10 : TRK_1;
                end
                TRK_10: begin
                    next_state = (bit_in == PATTERN[2]) ? TRK_101 : TRK_NONE;
                end
                TRK_101: begin
                    next_state = (bit_in == PATTERN[1]) ? TRK_1011 : TRK_10;
                end
                TRK_1011: begin
                    if (bit_in == PATTERN[0]) begin
                        hit        = 1'b1;
                        next_state = TRK_10;
                    end else begin
                        next_state = TRK_1;
                    end
                end
                default: begin
                    next_state = TRK_NONE;
                end
            endcase
        end
    end

endmodule

// File: rtl/serial_pattern_tx.sv
// -----------------------------------------------------------------------------
// serial_pattern_tx
//
// Serial bit-stream source for the sequence detectors. A frame of up to W bits
// is captured on start and shifted out MSB-first (first bit = data[len-1]),
// one bit per clock on `j`, optionally repeated back-to-back. An internal
// 10110 tracker counts occurrences in the transmitted stream so a bench has a
// golden count to compare with a detector's output pulses.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   start      in   transmit request, only looked at in IDLE
//   data       in   frame bits (W)
//   len        in   frame length in bits (LW); 0 is ignored, >W clamps to W
//   repeat_en  in   resend the frame with no gap, checked at each frame end
//   stop       in   abort the frame currently shifting
//   clr_cnt    in   synchronous clear of match_cnt and the tracker
//   j          out  serial bit (IDLE_BIT when nothing is sent)
//   valid      out  j carries a frame bit
//   busy       out  transmitter in SHIFT or DONE
//   done       out  one-cycle pulse after a frame ends or is aborted
//   match_cnt  out  saturating count of 10110 occurrences sent (CW)
// -----------------------------------------------------------------------------
module serial_pattern_tx
    import serial_pkg::*;
#(
    parameter int   W        = 16,
    parameter int   LW       = $clog2(W + 1),
    parameter logic IDLE_BIT = 1'b0,
    parameter int   CW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  data,
    input  logic [LW-1:0] len,
    input  logic          repeat_en,
    input  logic          stop,
    input  logic          clr_cnt,
    output logic          j,
    output logic          valid,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] match_cnt
);

    tx_state_t     state;
    tx_state_t     next_state;

    // frame holds the captured data left-aligned so that bit W-1 is always
    // the first bit to send; shreg is the working copy for the current pass.
    logic [W-1:0]  frame;
    logic [W-1:0]  shreg;
    logic [LW-1:0] flen;
    logic [LW-1:0] remaining;

    logic [W-1:0]  next_frame;
    logic [W-1:0]  next_shreg;
    logic [LW-1:0] next_flen;
    logic [LW-1:0] next_remaining;
    logic          next_j;
    logic          next_valid;
    logic          next_busy;
    logic          next_done;

    logic [LW-1:0] len_clamped;
    logic [LW-1:0] shift_amt;
    logic [W-1:0]  aligned;
    logic          hit;

    // Clamp the requested length and left-align the frame so the shifter does
    // not need to know where the first bit sits within data.
    always_comb begin
        len_clamped = (int'(len) > W) ? LW'(W) : len;
        shift_amt   = LW'(W) - len_clamped;
        aligned     = data << shift_amt;
    end

    // Control state and every output are registered together, so j, valid,
    // busy and done all change on the same edge as the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            frame     <= '0;
            shreg     <= '0;
            flen      <= '0;
            remaining <= '0;
            j         <= IDLE_BIT;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= next_state;
            frame     <= next_frame;
            shreg     <= next_shreg;
            flen      <= next_flen;
            remaining <= next_remaining;
            j         <= next_j;
            valid     <= next_valid;
            busy      <= next_busy;
            done      <= next_done;
        end
    end

    // Next-state and next-output logic. `remaining` counts the bits still to
    // come after the one currently on j, so remaining == 0 in SHIFT means the
    // last bit of the pass is on the wire and the frame-end decision is made
    // now. stop is tested first so it beats both a normal bit and a repeat.
    always_comb begin
        next_state     = state;
        next_frame     = frame;
        next_shreg     = shreg;
        next_flen      = flen;
        next_remaining = remaining;
        next_j         = IDLE_BIT;
        next_valid     = 1'b0;
        next_busy      = 1'b0;
        next_done      = 1'b0;

        case (state)
            IDLE: begin
                if (start && (len_clamped != '0)) begin
                    next_state     = SHIFT;
                    next_frame     = aligned;
                    next_flen      = len_clamped;
                    next_j         = aligned[W-1];
                    next_shreg     = aligned << 1;
                    next_remaining = len_clamped - LW'(1);
                    next_valid     = 1'b1;
                    next_busy      = 1'b1;
                end
            end

            SHIFT: begin
                if (stop) begin
                    next_state = DONE;
                    next_done  = 1'b1;
                    next_busy  = 1'b1;
                end else if (remaining != '0) begin
                    next_j         = shreg[W-1];
                    next_shreg     = shreg << 1;
                    next_remaining = remaining - LW'(1);
                    next_valid     = 1'b1;
                    next_busy      = 1'b1;
                end else if (repeat_en) begin
                    next_j         = frame[W-1];
                    next_shreg     = frame << 1;
                    next_remaining = flen - LW'(1);
                    next_valid     = 1'b1;
                    next_busy      = 1'b1;
                end else begin
                    next_state = DONE;
                    next_done  = 1'b1;
                    next_busy  = 1'b1;
                end
            end

            DONE: begin
                next_state = IDLE;
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // The tracker watches the registered output, so a match is counted on
    // the edge that ends the completing bit's cycle.
    pattern_tracker u_tracker (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr_cnt),
        .bit_in  (j & valid),
        .bit_vld (valid),
        .hit     (hit)
    );

    // Match counter: clear beats an increment in the same cycle, and the
    // count sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_cnt <= '0;
        end else if (clr_cnt) begin
            match_cnt <= '0;
        end else if (hit && (match_cnt != '1)) begin
            match_cnt <= match_cnt + CW'(1);
        end
    end

endmodule
